// File: rtl/cmac_link_sequencer_if.sv
// Control/status bundle between the AXI config block, the CMAC pins and the link sequencer.
interface cmac_link_sequencer_if;
  logic        enable;
  logic        restart;
  logic        stat_rx_aligned;
  logic        cmac_reset;
  logic        ctl_rx_enable;
  logic        ctl_tx_enable;
  logic        ctl_tx_send_rfi;
  logic        link_up;
  logic        fault;
  logic [3:0]  retry_count;
  logic [15:0] link_drops;
  logic [2:0]  seq_state;

  // Config block and CMAC status side: drives the controls, observes the sequencer.
  modport master (
    output enable, restart, stat_rx_aligned,
    input  cmac_reset, ctl_rx_enable, ctl_tx_enable, ctl_tx_send_rfi,
    input  link_up, fault, retry_count, link_drops, seq_state
  );

  // Sequencer side.
  modport slave (
    input  enable, restart, stat_rx_aligned,
    output cmac_reset, ctl_rx_enable, ctl_tx_enable, ctl_tx_send_rfi,
    output link_up, fault, retry_count, link_drops, seq_state
  );
endinterface

// File: rtl/cmac_link_sequencer.sv
// CMAC port bring-up sequencer: reset pulse, wait for debounced RX alignment, enable TX,
// retry on alignment timeout and re-sequence on link loss.
module cmac_link_sequencer #(
  parameter int unsigned CLK_HZ              = 250000000,
  parameter int unsigned RESET_USECS         = 100,
  parameter int unsigned ALIGN_TIMEOUT_USECS = 10000,
  parameter int unsigned DEBOUNCE_CYCLES     = 1024,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input logic                  clk,
  input logic                  reset,
  cmac_link_sequencer_if.slave bus
);

  localparam int unsigned     CycPerUs = CLK_HZ / 1000000;
  localparam logic [31:0]     ResetCyc = 32'(CycPerUs * RESET_USECS);
  localparam logic [31:0]     AlignCyc = 32'(CycPerUs * ALIGN_TIMEOUT_USECS);
  localparam int unsigned     DebW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DebW-1:0] DebDone  = DebW'(DEBOUNCE_CYCLES);
  localparam logic [3:0]      MaxRetry = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StReset     = 3'd1,
    StWaitAlign = 3'd2,
    StUp        = 3'd3,
    StFault     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      timer_q, timer_d;
  logic [DebW-1:0]  deb_q, deb_d;
  logic [3:0]       retry_q, retry_d;
  logic [15:0]      link_drops_q, link_drops_d;
  logic [1:0]       sync_q;
  logic             aligned;

  logic cmac_reset_q, cmac_reset_d;
  logic rx_en_q, rx_en_d;
  logic tx_en_q, tx_en_d;
  logic rfi_q, rfi_d;
  logic link_up_q, link_up_d;
  logic fault_q, fault_d;

  // Two-flop synchronizer for the asynchronous CMAC aligned status.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.stat_rx_aligned};
    end
  end

  assign aligned = sync_q[1];

  // Next-state logic: enable=0 beats restart, which beats the normal state transitions.
  always_comb begin
    state_d      = state_q;
    timer_d      = (timer_q != 32'd0) ? timer_q - 32'd1 : timer_q;
    deb_d        = deb_q;
    retry_d      = retry_q;
    link_drops_d = link_drops_q;

    if (!bus.enable) begin
      state_d = StIdle;
      timer_d = 32'd0;
      deb_d   = '0;
      retry_d = 4'd0;
    end else if (bus.restart && (state_q != StIdle)) begin
      state_d = StReset;
      timer_d = ResetCyc;
      retry_d = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StReset;
          timer_d = ResetCyc;
        end
        StReset: begin
          if (timer_q == 32'd0) begin
            state_d = StWaitAlign;
            timer_d = AlignCyc;
            deb_d   = '0;
          end
        end
        StWaitAlign: begin
          // A completed debounce takes precedence over a timeout in the same cycle.
          if (deb_q == DebDone) begin
            state_d = StUp;
            retry_d = 4'd0;
          end else if (timer_q == 32'd0) begin
            if (retry_q == MaxRetry) begin
              state_d = StFault;
            end else begin
              state_d = StReset;
              timer_d = ResetCyc;
              retry_d = retry_q + 4'd1;
            end
          end else begin
            deb_d = aligned ? deb_q + DebW'(1) : '0;
          end
        end
        StUp: begin
          if (!aligned) begin
            state_d = StReset;
            timer_d = ResetCyc;
            if (link_drops_q != 16'hFFFF) begin
              link_drops_d = link_drops_q + 16'd1;
            end
          end
        end
        StFault: begin
          // Held here until enable drops or restart is strobed.
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output decode of the next state, so the registered outputs track the state register.
  always_comb begin
    cmac_reset_d = 1'b1;
    rx_en_d      = 1'b0;
    tx_en_d      = 1'b0;
    rfi_d        = 1'b0;
    link_up_d    = 1'b0;
    fault_d      = 1'b0;
    unique case (state_d)
      StWaitAlign: begin
        cmac_reset_d = 1'b0;
        rx_en_d      = 1'b1;
        rfi_d        = 1'b1;
      end
      StUp: begin
        cmac_reset_d = 1'b0;
        rx_en_d      = 1'b1;
        tx_en_d      = 1'b1;
        link_up_d    = 1'b1;
      end
      StFault: fault_d = 1'b1;
      default: ;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      timer_q      <= 32'd0;
      deb_q        <= '0;
      retry_q      <= 4'd0;
      link_drops_q <= 16'd0;
      cmac_reset_q <= 1'b1;
      rx_en_q      <= 1'b0;
      tx_en_q      <= 1'b0;
      rfi_q        <= 1'b0;
      link_up_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      deb_q        <= deb_d;
      retry_q      <= retry_d;
      link_drops_q <= link_drops_d;
      cmac_reset_q <= cmac_reset_d;
      rx_en_q      <= rx_en_d;
      tx_en_q      <= tx_en_d;
      rfi_q        <= rfi_d;
      link_up_q    <= link_up_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.cmac_reset      = cmac_reset_q;
  assign bus.ctl_rx_enable   = rx_en_q;
  assign bus.ctl_tx_enable   = tx_en_q;
  assign bus.ctl_tx_send_rfi = rfi_q;
  assign bus.link_up         = link_up_q;
  assign bus.fault           = fault_q;
  assign bus.retry_count     = retry_q;
  assign bus.link_drops      = link_drops_q;
  assign bus.seq_state       = state_q;

endmodule

// File: tb/tb_cmac_link_sequencer.sv
// Bench for cmac_link_sequencer: behavioural model, per-cycle comparison, directed scenarios
// with literal expectations, then a randomized phase.
module tb_cmac_link_sequencer;

  localparam int unsigned RCYC = 20;  // 10 cycles/us * 2 us
  localparam int unsigned ACYC = 50;  // 10 cycles/us * 5 us
  localparam int unsigned DEB  = 8;
  localparam int unsigned MAXR = 2;

  logic clk;
  logic rst, en, rs, al;
  logic chk_on;
  int   n_checks;
  int   n_fail;

  // Model: state uses the seq_state codes 0 IDLE, 1 RESET, 2 WAIT_ALIGN, 3 UP, 4 FAULT.
  int unsigned m_st, m_timer, m_run, m_retry, m_drops;
  logic        m_sync0, m_sync1;

  cmac_link_sequencer_if bus ();

  assign bus.enable          = en;
  assign bus.restart         = rs;
  assign bus.stat_rx_aligned = al;

  cmac_link_sequencer #(
    .CLK_HZ              (10000000),
    .RESET_USECS         (2),
    .ALIGN_TIMEOUT_USECS (5),
    .DEBOUNCE_CYCLES     (8),
    .MAX_RETRIES         (2)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] mdl,
                     input logic [31:0] lit);
    check({name, "_dut"}, act, lit);
    check({name, "_model"}, mdl, lit);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One clock of the behavioural model, using the inputs as they stand before the edge.
  task automatic model_step();
    logic a;
    a = m_sync1;
    if (rst) begin
      m_st = 0; m_timer = 0; m_run = 0; m_retry = 0; m_drops = 0;
      m_sync0 = 1'b0; m_sync1 = 1'b0;
    end else begin
      m_sync1 = m_sync0;
      m_sync0 = al;
      if (!en) begin
        m_st = 0; m_timer = 0; m_retry = 0;
      end else if (rs && m_st != 0) begin
        m_st = 1; m_timer = RCYC; m_retry = 0;
      end else begin
        case (m_st)
          0: begin m_st = 1; m_timer = RCYC; end
          1: begin
            if (m_timer == 0) begin m_st = 2; m_timer = ACYC; m_run = 0; end
            else m_timer--;
          end
          2: begin
            if (m_run >= DEB) begin
              m_st = 3; m_retry = 0;
            end else if (m_timer == 0) begin
              if (m_retry == MAXR) m_st = 4;
              else begin m_retry++; m_st = 1; m_timer = RCYC; end
            end else begin
              m_timer--;
              m_run = a ? m_run + 1 : 0;
            end
          end
          3: begin
            if (!a) begin
              m_st = 1; m_timer = RCYC;
              if (m_drops < 65535) m_drops++;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    m_st = 0; m_timer = 0; m_run = 0; m_retry = 0; m_drops = 0;
    m_sync0 = 1'b0; m_sync1 = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("seq_state",       32'(bus.seq_state),       32'(m_st));
      check("cmac_reset",      32'(bus.cmac_reset),      32'(m_st != 2 && m_st != 3));
      check("ctl_rx_enable",   32'(bus.ctl_rx_enable),   32'(m_st == 2 || m_st == 3));
      check("ctl_tx_enable",   32'(bus.ctl_tx_enable),   32'(m_st == 3));
      check("ctl_tx_send_rfi", 32'(bus.ctl_tx_send_rfi), 32'(m_st == 2));
      check("link_up",         32'(bus.link_up),         32'(m_st == 3));
      check("fault",           32'(bus.fault),           32'(m_st == 4));
      check("retry_count",     32'(bus.retry_count),     32'(m_retry));
      check("link_drops",      32'(bus.link_drops),      32'(m_drops));
    end
  end

  initial begin
    int mode;
    rst = 1'b1; en = 1'b0; rs = 1'b0; al = 1'b1; chk_on = 1'b0;
    n_checks = 0; n_fail = 0;
    step(2);
    chk_on = 1'b1;
    pin("rst_state", 32'(bus.seq_state), 32'(m_st), 0);
    pin("rst_cmac_reset", 32'(bus.cmac_reset), 32'(m_st != 2 && m_st != 3), 1);
    pin("rst_drops", 32'(bus.link_drops), 32'(m_drops), 0);
    rst = 1'b0;
    step(4);

    // Bring-up with aligned tied high.
    en = 1'b1;
    step(21);
    pin("t1_cmac_reset_hold", 32'(bus.cmac_reset), 32'(m_st != 2 && m_st != 3), 1);
    step(1);
    pin("t1_cmac_reset_fall", 32'(bus.cmac_reset), 32'(m_st != 2 && m_st != 3), 0);
    step(8);
    pin("t1_link_up_early", 32'(bus.link_up), 32'(m_st == 3), 0);
    step(1);
    pin("t1_link_up", 32'(bus.link_up), 32'(m_st == 3), 1);
    pin("t1_state_up", 32'(bus.seq_state), 32'(m_st), 3);
    pin("t1_tx_en", 32'(bus.ctl_tx_enable), 32'(m_st == 3), 1);

    // Single-cycle alignment drop in UP.
    al = 1'b0; step(1); al = 1'b1; step(1);
    pin("t3_still_up", 32'(bus.link_up), 32'(m_st == 3), 1);
    step(1);
    pin("t3_down", 32'(bus.link_up), 32'(m_st == 3), 0);
    pin("t3_drops", 32'(bus.link_drops), 32'(m_drops), 1);
    pin("t3_state", 32'(bus.seq_state), 32'(m_st), 1);
    step(30);
    pin("t3_up_again", 32'(bus.link_up), 32'(m_st == 3), 1);

    // Alignment never arrives: two retries then FAULT.
    en = 1'b0; al = 1'b0; step(1);
    pin("t2_idle", 32'(bus.seq_state), 32'(m_st), 0);
    en = 1'b1;
    step(73);
    pin("t2_retry1", 32'(bus.retry_count), 32'(m_retry), 1);
    step(72);
    pin("t2_retry2", 32'(bus.retry_count), 32'(m_retry), 2);
    step(71);
    pin("t2_pre_fault", 32'(bus.seq_state), 32'(m_st), 2);
    step(1);
    pin("t2_fault_state", 32'(bus.seq_state), 32'(m_st), 4);
    pin("t2_fault", 32'(bus.fault), 32'(m_st == 4), 1);
    step(5);
    pin("t2_fault_hold", 32'(bus.seq_state), 32'(m_st), 4);
    en = 1'b0; step(1);
    pin("t2_fault_clr", 32'(bus.fault), 32'(m_st == 4), 0);
    pin("t2_retry_clr", 32'(bus.retry_count), 32'(m_retry), 0);

    // Restart in WAIT_ALIGN with one retry used.
    en = 1'b1;
    step(101);
    pin("t5_wait", 32'(bus.seq_state), 32'(m_st), 2);
    pin("t5_retry_pre", 32'(bus.retry_count), 32'(m_retry), 1);
    rs = 1'b1; step(1); rs = 1'b0;
    pin("t5_reset", 32'(bus.seq_state), 32'(m_st), 1);
    pin("t5_retry_clr", 32'(bus.retry_count), 32'(m_retry), 0);
    step(20);
    pin("t5_reload_hold", 32'(bus.seq_state), 32'(m_st), 1);
    step(1);
    pin("t5_reload_done", 32'(bus.seq_state), 32'(m_st), 2);
    rs = 1'b1; en = 1'b0; step(1); rs = 1'b0;
    pin("t5_restart_dis", 32'(bus.seq_state), 32'(m_st), 0);

    // Aligned toggling every 5 cycles never debounces.
    en = 1'b1;
    for (int i = 0; i < 73; i++) begin
      al = ((i / 5) % 2) == 0;
      step(1);
    end
    pin("t4_toggle_timeout", 32'(bus.seq_state), 32'(m_st), 1);
    pin("t4_toggle_retry", 32'(bus.retry_count), 32'(m_retry), 1);
    en = 1'b0; al = 1'b0; step(1);

    // Debounce completes on the exact timeout cycle: UP wins.
    en = 1'b1;
    step(62);
    al = 1'b1;
    step(10);
    pin("t4_race_pre", 32'(bus.seq_state), 32'(m_st), 2);
    step(1);
    pin("t4_race_up", 32'(bus.seq_state), 32'(m_st), 3);

    // link_drops saturation, starting from a preloaded count.
    step(1);
    #2;
    force dut.link_drops_q = 16'hFFFE;
    m_drops = 65534;
    #1;
    release dut.link_drops_q;
    step(1);
    al = 1'b0; step(1); al = 1'b1; step(2);
    pin("t3_sat_first", 32'(bus.link_drops), 32'(m_drops), 32'hFFFF);
    step(30);
    pin("t3_sat_up", 32'(bus.link_up), 32'(m_st == 3), 1);
    al = 1'b0; step(1); al = 1'b1; step(2);
    pin("t3_sat_hold", 32'(bus.link_drops), 32'(m_drops), 32'hFFFF);
    step(30);
    pin("t6_up", 32'(bus.seq_state), 32'(m_st), 3);

    // Synchronous reset mid-UP, then restart from IDLE with enable held.
    rst = 1'b1; step(1);
    pin("t6_state", 32'(bus.seq_state), 32'(m_st), 0);
    pin("t6_cmac_reset", 32'(bus.cmac_reset), 32'(m_st != 2 && m_st != 3), 1);
    pin("t6_link_up", 32'(bus.link_up), 32'(m_st == 3), 0);
    pin("t6_drops", 32'(bus.link_drops), 32'(m_drops), 0);
    rst = 1'b0;
    step(21);
    pin("t6_cmac_hold", 32'(bus.cmac_reset), 32'(m_st != 2 && m_st != 3), 1);
    step(1);
    pin("t6_cmac_fall", 32'(bus.cmac_reset), 32'(m_st != 2 && m_st != 3), 0);

    // Randomized phase: aligned flip rate changes every 500 cycles.
    mode = 0;
    for (int i = 0; i < 20000; i++) begin
      if (i % 500 == 0) mode = int'($urandom_range(0, 2));
      case (mode)
        0:       if ($urandom_range(0, 2) == 0) al = ~al;
        1:       if ($urandom_range(0, 39) == 0) al = ~al;
        default: if ($urandom_range(0, 399) == 0) al = ~al;
      endcase
      en  = ($urandom_range(0, 599) != 0);
      rs  = ($urandom_range(0, 499) == 0);
      rst = ($urandom_range(0, 2999) == 0);
      step(1);
    end
    rst = 1'b0; en = 1'b0; rs = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
